serial_adder: RTL

Parametrised multi-cycle adder built around a registered carry chain. It adds two WIDTH-bit operands DIGIT bits per clock. A start/busy/done handshake frames each operation. It is the sequential successor to the team's single-bit full adder and sits wherever area matters more than latency, such as accumulators and checksum units.

---
 rtl/serial_adder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock over a registered carry.
// Optional subtract mode under SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [DIGIT:0]   slice;
  logic             msb_cin;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Subtraction folds into the add: invert B once at latch, force carry-in.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  always_comb begin
    slice = {1'b0, a_sh[DIGIT-1:0]}
          + {1'b0, b_sh[DIGIT-1:0]}
          + {{DIGIT{1'b0}}, carry};
    msb_cin = slice[DIGIT-1]
            ^ a_sh[DIGIT-1]
            ^ b_sh[DIGIT-1];
    acc_nxt = (acc >> DIGIT)
            | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sum/cout/ovf are shadow registers: only the final slice updates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b_in;
      carry <= c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= slice[DIGIT];
      cnt   <= cnt + 1'b1;
      acc   <= acc_nxt;
      if (last) begin
        sum  <= acc_nxt;
        cout <= slice[DIGIT];
        ovf  <= msb_cin ^ slice[DIGIT];
      end
    end
  end

endmodule
